// File: rtl/score_button_ctrl.sv
// Button front-end for the BCD scoreboard: sync, debounce, inc/dec pulses, clear.
// Define SCORE_BTN_REPEAT_EN to enable hold-to-repeat on inc/dec.
module score_button_ctrl #(
    parameter int DEB_CYCLES    = 4,
    parameter int CLR_HOLD      = 8,
    parameter int CLR_PULSE     = 6,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc,
    input  logic btn_dec,
    output logic inc_out,
    output logic dec_out,
    output logic clr_out
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(CLR_HOLD + 1);
    localparam int PW = $clog2(CLR_PULSE + 1);

    if (CLR_PULSE < 5 || REPEAT_PERIOD < 2 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_cfg
        $error("score_button_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE, INC_HOLD, DEC_HOLD, BOTH_HOLD, CLEAR, WAIT_REL
    } state_e;

    logic [1:0]    inc_sync_q, dec_sync_q;
    logic          deb_inc_q, deb_dec_q;
    logic          deb_inc_d, deb_dec_d;
    logic [DW-1:0] inc_cnt_q, dec_cnt_q;
    logic [DW-1:0] inc_cnt_d, dec_cnt_d;
    state_e        state_q;
    logic [HW-1:0] hold_q;
    logic [PW-1:0] clr_cnt_q;
`ifdef SCORE_BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_q;
`endif

    // Level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_inc_d = deb_inc_q;
        inc_cnt_d = '0;
        if (inc_sync_q[1] != deb_inc_q) begin
            if (inc_cnt_q == DW'(DEB_CYCLES - 1)) deb_inc_d = inc_sync_q[1];
            else inc_cnt_d = inc_cnt_q + DW'(1);
        end
    end

    always_comb begin
        deb_dec_d = deb_dec_q;
        dec_cnt_d = '0;
        if (dec_sync_q[1] != deb_dec_q) begin
            if (dec_cnt_q == DW'(DEB_CYCLES - 1)) deb_dec_d = dec_sync_q[1];
            else dec_cnt_d = dec_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inc_sync_q <= '0;
            dec_sync_q <= '0;
            deb_inc_q  <= 1'b0;
            deb_dec_q  <= 1'b0;
            inc_cnt_q  <= '0;
            dec_cnt_q  <= '0;
        end else begin
            inc_sync_q <= {inc_sync_q[0], btn_inc};
            dec_sync_q <= {dec_sync_q[0], btn_dec};
            deb_inc_q  <= deb_inc_d;
            deb_dec_q  <= deb_dec_d;
            inc_cnt_q  <= inc_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            clr_cnt_q <= '0;
            inc_out   <= 1'b0;
            dec_out   <= 1'b0;
            clr_out   <= 1'b0;
`ifdef SCORE_BTN_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            inc_out <= 1'b0;
            dec_out <= 1'b0;
            clr_out <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (deb_inc_q && deb_dec_q) begin
                        state_q <= BOTH_HOLD;
                        hold_q  <= '0;
                    end else if (deb_inc_q) begin
                        state_q <= INC_HOLD;
                        inc_out <= 1'b1;
                    end else if (deb_dec_q) begin
                        state_q <= DEC_HOLD;
                        dec_out <= 1'b1;
                    end
                end
                INC_HOLD, DEC_HOLD: begin
                    if (state_q == INC_HOLD ? !deb_inc_q : !deb_dec_q) begin
                        state_q <= IDLE;
`ifdef SCORE_BTN_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else if (state_q == INC_HOLD ? deb_dec_q : deb_inc_q) begin
                        state_q <= BOTH_HOLD;
                        hold_q  <= '0;
`ifdef SCORE_BTN_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end
`ifdef SCORE_BTN_REPEAT_EN
                    else if (rep_q == RW'(REPEAT_DELAY - 1)) begin
                        // Rewind so the next pulse lands REPEAT_PERIOD later.
                        rep_q   <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
                        inc_out <= (state_q == INC_HOLD);
                        dec_out <= (state_q == DEC_HOLD);
                    end else begin
                        rep_q <= rep_q + RW'(1);
                    end
`endif
                end
                BOTH_HOLD: begin
                    if (deb_inc_q && deb_dec_q) begin
                        if (hold_q == HW'(CLR_HOLD - 1)) begin
                            state_q   <= CLEAR;
                            hold_q    <= '0;
                            clr_cnt_q <= '0;
                            clr_out   <= 1'b1;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end else begin
                        state_q <= WAIT_REL;
                        hold_q  <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == PW'(CLR_PULSE - 1)) begin
                        state_q   <= WAIT_REL;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + PW'(1);
                        clr_out   <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!deb_inc_q && !deb_dec_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_button_ctrl.sv
// Bench for score_button_ctrl: directed scenarios plus random presses vs. a reference model.
`timescale 1ns/1ps
module tb_score_button_ctrl;
    localparam int DEB = 4;
    localparam int CH  = 8;
    localparam int CP  = 6;
    localparam int RD  = 16;
    localparam int RP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_inc = 1'b0;
    logic btn_dec = 1'b0;
    logic inc_out, dec_out, clr_out;

    always #5 clk = ~clk;

    score_button_ctrl #(
        .DEB_CYCLES(DEB), .CLR_HOLD(CH), .CLR_PULSE(CP),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .inc_out(inc_out), .dec_out(dec_out), .clr_out(clr_out)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: raw history windows plus a press-level state and its age.
    typedef enum {M_IDLE, M_INC, M_DEC, M_BOTH, M_CLR, M_WAIT} mstate_e;
    logic    hq_i[$];
    logic    hq_d[$];
    logic    m_deb_i = 1'b0, m_deb_d = 1'b0;
    mstate_e m_st = M_IDLE;
    int      m_age = 0;
    logic    m_inc = 1'b0, m_dec = 1'b0, m_clr = 1'b0;

    function automatic logic settled_other(input logic q[$], input logic lvl);
        for (int k = 0; k < DEB; k++)
            if (q[q.size() - 3 - k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic rep_hit(input int age);
`ifdef SCORE_BTN_REPEAT_EN
        return (age >= RD) && ((age - RD) % RP == 0);
`else
        return (age < 0);
`endif
    endfunction

    task automatic model_step(input logic r, input logic ri, input logic rd);
        logic bi, bd;
        if (!r) begin
            hq_i.delete();
            hq_d.delete();
            for (int k = 0; k < DEB + 2; k++) begin
                hq_i.push_back(1'b0);
                hq_d.push_back(1'b0);
            end
            m_deb_i = 0; m_deb_d = 0; m_st = M_IDLE; m_age = 0;
            m_inc = 0; m_dec = 0; m_clr = 0;
        end else begin
            bi = m_deb_i; bd = m_deb_d;
            m_inc = 0; m_dec = 0; m_clr = 0;
            case (m_st)
                M_IDLE:
                    if (bi && bd) begin m_st = M_BOTH; m_age = 0; end
                    else if (bi) begin m_st = M_INC; m_age = 0; m_inc = 1; end
                    else if (bd) begin m_st = M_DEC; m_age = 0; m_dec = 1; end
                M_INC:
                    if (!bi) m_st = M_IDLE;
                    else if (bd) begin m_st = M_BOTH; m_age = 0; end
                    else begin m_age++; m_inc = rep_hit(m_age); end
                M_DEC:
                    if (!bd) m_st = M_IDLE;
                    else if (bi) begin m_st = M_BOTH; m_age = 0; end
                    else begin m_age++; m_dec = rep_hit(m_age); end
                M_BOTH:
                    if (bi && bd) begin
                        m_age++;
                        if (m_age == CH) begin m_st = M_CLR; m_age = 0; m_clr = 1; end
                    end else m_st = M_WAIT;
                M_CLR: begin
                    m_age++;
                    if (m_age < CP) m_clr = 1;
                    else m_st = M_WAIT;
                end
                M_WAIT:
                    if (!bi && !bd) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
            hq_i.push_back(ri); void'(hq_i.pop_front());
            hq_d.push_back(rd); void'(hq_d.pop_front());
            if (settled_other(hq_i, m_deb_i)) m_deb_i = ~m_deb_i;
            if (settled_other(hq_d, m_deb_d)) m_deb_d = ~m_deb_d;
        end
    endtask

    int cyc = 0;
    int inc_n = 0, dec_n = 0, clr_n = 0, clr_runs = 0;
    int first_inc = -1;
    int inc_cycs[$];
    logic p_pulse = 1'b0, p_clr = 1'b0;

    always @(posedge clk) begin
        model_step(rst, btn_inc, btn_dec);
        cyc++;
        #1;
        chk("inc_out", inc_out, m_inc);
        chk("dec_out", dec_out, m_dec);
        chk("clr_out", clr_out, m_clr);
        chk("exclusive", 32'(inc_out) + 32'(dec_out) + 32'(clr_out) <= 1, 1);
        chk("no_back_to_back", (inc_out | dec_out) & p_pulse, 0);
        if (inc_out === 1'b1) begin
            inc_n++;
            inc_cycs.push_back(cyc);
            if (first_inc < 0) first_inc = cyc;
        end
        if (dec_out === 1'b1) dec_n++;
        if (clr_out === 1'b1) begin
            clr_n++;
            if (!p_clr) clr_runs++;
        end
        p_pulse = inc_out | dec_out;
        p_clr = clr_out;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stats();
        inc_n = 0; dec_n = 0; clr_n = 0; clr_runs = 0;
        first_inc = -1;
        inc_cycs.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int w;
        int n_exp;
        int offs[8];
        offs = '{0, 16, 20, 24, 28, 32, 36, 40};

        rst = 0;
        tick(3);
        chk("reset_inc", inc_out, 0);
        chk("reset_dec", dec_out, 0);
        chk("reset_clr", clr_out, 0);
        rst = 1;
        tick(5);

        clear_stats();
        start = cyc;
        btn_inc = 1; tick(20);
        btn_inc = 0; tick(15);
`ifdef SCORE_BTN_REPEAT_EN
        n_exp = 2;
`else
        n_exp = 1;
`endif
        chk("t1_first_edge", first_inc - start, 7);
        chk("t1_inc_count", inc_n, n_exp);
        chk("t1_dec_count", dec_n, 0);
        chk("t1_clr_count", clr_n, 0);

        clear_stats();
        btn_dec = 1; tick(3);
        btn_dec = 0; tick(10);
        chk("t2_glitch_dec", dec_n, 0);

        clear_stats();
        btn_inc = 1; btn_dec = 1; tick(30);
        btn_inc = 0; btn_dec = 0; tick(12);
        chk("t3_clr_cycles", clr_n, 6);
        chk("t3_clr_runs", clr_runs, 1);
        chk("t3_inc_count", inc_n, 0);
        chk("t3_dec_count", dec_n, 0);
        clear_stats();
        start = cyc;
        btn_inc = 1; tick(10);
        btn_inc = 0; tick(15);
        chk("t3_new_press", inc_n, 1);
        chk("t3_new_edge", first_inc - start, 7);

        clear_stats();
        btn_inc = 1; tick(10);
        btn_dec = 1; tick(5);
        btn_inc = 0; btn_dec = 0; tick(15);
        chk("t4_inc_count", inc_n, 1);
        chk("t4_dec_count", dec_n, 0);
        chk("t4_clr_count", clr_n, 0);
        clear_stats();
        btn_inc = 1; tick(8);
        btn_inc = 0; tick(15);
        chk("t4_after_release", inc_n, 1);

        clear_stats();
        btn_inc = 1; btn_dec = 1;
        w = 0;
        while (clr_out !== 1'b1 && w < 40) begin
            tick(1);
            w++;
        end
        chk("t5_clr_seen", clr_out, 1);
        tick(2);
        rst = 0; btn_inc = 0; btn_dec = 0;
        tick(1);
        chk("t5_rst_clr", clr_out, 0);
        chk("t5_rst_inc", inc_out, 0);
        chk("t5_rst_dec", dec_out, 0);
        rst = 1;
        clear_stats();
        tick(3);
        start = cyc;
        btn_inc = 1; tick(10);
        btn_inc = 0; tick(15);
        chk("t5_no_more_clr", clr_n, 0);
        chk("t5_inc_count", inc_n, 1);
        chk("t5_inc_edge", first_inc - start, 7);

`ifdef SCORE_BTN_REPEAT_EN
        clear_stats();
        btn_inc = 1; tick(7 + 41);
        btn_inc = 0; tick(15);
        chk("t6_pulse_count_ge8", inc_cycs.size() >= 8, 1);
        if (inc_cycs.size() >= 8)
            for (int k = 0; k < 8; k++)
                chk("t6_offset", inc_cycs[k] - inc_cycs[0], offs[k]);
`endif

        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 0;
                tick($urandom_range(1, 2));
                rst = 1;
            end else begin
                btn_inc = 1'($urandom_range(0, 1));
                btn_dec = 1'($urandom_range(0, 1));
                tick($urandom_range(1, 35));
            end
        end
        btn_inc = 0; btn_dec = 0; rst = 1;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
